// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared single-port RAM port around mem_arbiter.
// slave = arbiter side, master = requesters plus RAM model side.
interface mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_done;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_write;
  logic                  ram_read;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_data_out,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_done, dm_rdata,
           ram_address, ram_data_in, ram_write, ram_read
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_data_out,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_done, dm_rdata,
           ram_address, ram_data_in, ram_write, ram_read
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of one single-port RAM; one transaction every 3 cycles.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise data always wins ties.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state;
  logic                  owner_fetch;
  logic                  ram_read_q;
  logic                  ram_write_q;
  logic                  if_rvalid_q;
  logic                  dm_done_q;
  logic [ADDR_WIDTH-1:0] ram_address_q;
  logic [DATA_WIDTH-1:0] ram_data_in_q;

  logic                  pick_if_c;
  logic                  pick_dm_c;
  logic                  accept_c;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // Set when the fetch port was the most recent winner; resets so data wins the first tie.
  logic last_fetch;

  always_comb begin
    pick_if_c = 1'b0;
    pick_dm_c = 1'b0;
    if (state == IDLE) begin
      if (bus.if_req && bus.dm_req) begin
        pick_dm_c = last_fetch;
        pick_if_c = !last_fetch;
      end else begin
        pick_dm_c = bus.dm_req;
        pick_if_c = bus.if_req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_fetch <= 1'b1;
    end else if (accept_c) begin
      last_fetch <= pick_if_c;
    end
  end
`else
  always_comb begin
    pick_if_c = 1'b0;
    pick_dm_c = 1'b0;
    if (state == IDLE) begin
      pick_dm_c = bus.dm_req;
      pick_if_c = bus.if_req && !bus.dm_req;
    end
  end
`endif

  assign accept_c = pick_if_c | pick_dm_c;

  // Transaction FSM: the RAM strobes live only in ISSUE, the response pulse only in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner_fetch   <= 1'b0;
      ram_read_q    <= 1'b0;
      ram_write_q   <= 1'b0;
      if_rvalid_q   <= 1'b0;
      dm_done_q     <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            state         <= ISSUE;
            owner_fetch   <= pick_if_c;
            ram_address_q <= pick_if_c ? bus.if_addr : bus.dm_addr;
            ram_read_q    <= pick_if_c | (pick_dm_c & !bus.dm_we);
            ram_write_q   <= pick_dm_c & bus.dm_we;
            if (pick_dm_c) begin
              ram_data_in_q <= bus.dm_wdata;
            end
          end
        end
        ISSUE: begin
          state       <= RESP;
          ram_read_q  <= 1'b0;
          ram_write_q <= 1'b0;
          if_rvalid_q <= owner_fetch;
          dm_done_q   <= !owner_fetch;
        end
        RESP: begin
          state       <= IDLE;
          if_rvalid_q <= 1'b0;
          dm_done_q   <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          ram_read_q  <= 1'b0;
          ram_write_q <= 1'b0;
          if_rvalid_q <= 1'b0;
          dm_done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_gnt      = pick_if_c;
  assign bus.dm_gnt      = pick_dm_c;
  assign bus.if_rvalid   = if_rvalid_q;
  assign bus.dm_done     = dm_done_q;
  assign bus.ram_read    = ram_read_q;
  assign bus.ram_write   = ram_write_q;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_data_in = ram_data_in_q;

  // RAM read data arrives in RESP, so it is forwarded straight through during the response pulse.
  assign bus.if_rdata = if_rvalid_q ? bus.ram_data_out : '0;
  assign bus.dm_rdata = dm_done_q   ? bus.ram_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a registered-read RAM model.
// Expectations follow MEM_ARBITER_ROUND_ROBIN_EN when the bench is built with it.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [31:0] D_BEEF = 32'hDEAD_BEEF;
  localparam logic [31:0] D_CAFE = 32'hCAFE_F00D;
  localparam logic [31:0] D_BAD  = 32'h0BAD_C0DE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: writes and reads sampled on the rising edge, read data valid the next cycle.
  logic [31:0] mem [0:255];
  logic [31:0] ram_q = 32'h0;
  int          n_access = 0;
  bit          stray = 1'b0;
  assign bus.ram_data_out = ram_q;

  always @(posedge clk) begin
    if (bus.ram_read) ram_q <= mem[bus.ram_address[7:0]];
    if (bus.ram_write) mem[bus.ram_address[7:0]] = bus.ram_data_in;
    if (bus.ram_read || bus.ram_write) begin
      n_access = n_access + 1;
      if (bus.ram_address == 16'h0050) stray = 1'b1;
    end
  end

  typedef struct {
    logic        if_req;
    logic [15:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_rd;
    logic        e_wr;
    logic [15:0] e_addr;
    logic        e_if_rvalid;
    logic        e_dm_done;
    logic        e_data_chk;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic ir, input logic [15:0] ia,
                              input logic dr, input logic dw, input logic [15:0] da,
                              input logic [31:0] dd,
                              input logic eig, input logic edg, input logic erd,
                              input logic ewr, input logic [15:0] ea,
                              input logic eiv, input logic edd,
                              input logic ec, input logic [31:0] ed);
    vec_t r;
    r.if_req = ir;  r.if_addr = ia;  r.dm_req = dr;  r.dm_we = dw;
    r.dm_addr = da; r.dm_wdata = dd;
    r.e_if_gnt = eig; r.e_dm_gnt = edg; r.e_rd = erd; r.e_wr = ewr; r.e_addr = ea;
    r.e_if_rvalid = eiv; r.e_dm_done = edd; r.e_data_chk = ec; r.e_data = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr,
                       input logic dw, input logic [15:0] da, input logic [31:0] dd);
    bus.if_req = ir; bus.if_addr = ia; bus.dm_req = dr; bus.dm_we = dw;
    bus.dm_addr = da; bus.dm_wdata = dd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " if_gnt"},      32'(bus.if_gnt),      32'h0);
    chk({tag, " dm_gnt"},      32'(bus.dm_gnt),      32'h0);
    chk({tag, " if_rvalid"},   32'(bus.if_rvalid),   32'h0);
    chk({tag, " dm_done"},     32'(bus.dm_done),     32'h0);
    chk({tag, " ram_read"},    32'(bus.ram_read),    32'h0);
    chk({tag, " ram_write"},   32'(bus.ram_write),   32'h0);
    chk({tag, " ram_address"}, 32'(bus.ram_address), 32'h0);
    chk({tag, " ram_data_in"}, bus.ram_data_in,      32'h0);
    chk({tag, " if_rdata"},    bus.if_rdata,         32'h0);
    chk({tag, " dm_rdata"},    bus.dm_rdata,         32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h20] = D_CAFE;
    mem[8'h04] = D_BAD;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);

    // Data write, then data read of the same word.
    tbl.push_back(mk(0,16'h0, 1,1,16'h0010,D_BEEF, 0,1,0,0,16'h0,      0,0, 0,32'h0));
    tbl.push_back(mk(0,16'h0, 0,0,16'h0,32'h0,     0,0,0,1,16'h0010,   0,0, 1,D_BEEF));
    tbl.push_back(mk(0,16'h0, 0,0,16'h0,32'h0,     0,0,0,0,16'h0,      0,1, 0,32'h0));
    tbl.push_back(mk(0,16'h0, 1,0,16'h0010,32'h0,  0,1,0,0,16'h0,      0,0, 0,32'h0));
    tbl.push_back(mk(0,16'h0, 0,0,16'h0,32'h0,     0,0,1,0,16'h0010,   0,0, 0,32'h0));
    tbl.push_back(mk(0,16'h0, 0,0,16'h0,32'h0,     0,0,0,0,16'h0,      0,1, 1,D_BEEF));
    // Fetch alone, held high: grant every third cycle.
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(1,16'h0020, 0,0,16'h0,32'h0, 1,0,0,0,16'h0,    0,0, 0,32'h0));
      tbl.push_back(mk(1,16'h0020, 0,0,16'h0,32'h0, 0,0,1,0,16'h0020, 0,0, 0,32'h0));
      tbl.push_back(mk(1,16'h0020, 0,0,16'h0,32'h0, 0,0,0,0,16'h0,    1,0, 1,D_CAFE));
    end
    // Both requesting continuously; the last winner before this was fetch.
    for (int k = 0; k < 4; k++) begin
      logic w_if;
      w_if = RR && (k % 2 == 1);
      tbl.push_back(mk(1,16'h0004, 1,0,16'h0010,32'h0, w_if,!w_if,0,0,16'h0, 0,0, 0,32'h0));
      tbl.push_back(mk(1,16'h0004, 1,0,16'h0010,32'h0, 0,0,1,0, w_if ? 16'h0004 : 16'h0010,
                       0,0, 0,32'h0));
      tbl.push_back(mk(1,16'h0004, 1,0,16'h0010,32'h0, 0,0,0,0,16'h0, w_if,!w_if,
                       1, w_if ? D_BAD : D_BEEF));
    end
    tbl.push_back(mk(0,16'h0, 0,0,16'h0,32'h0, 0,0,0,0,16'h0, 0,0, 0,32'h0));

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i].if_req, tbl[i].if_addr, tbl[i].dm_req, tbl[i].dm_we,
            tbl[i].dm_addr, tbl[i].dm_wdata);
      @(negedge clk);
      chk($sformatf("v%0d if_gnt", i),    32'(bus.if_gnt),    32'(tbl[i].e_if_gnt));
      chk($sformatf("v%0d dm_gnt", i),    32'(bus.dm_gnt),    32'(tbl[i].e_dm_gnt));
      chk($sformatf("v%0d ram_read", i),  32'(bus.ram_read),  32'(tbl[i].e_rd));
      chk($sformatf("v%0d ram_write", i), 32'(bus.ram_write), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d if_rvalid", i), 32'(bus.if_rvalid), 32'(tbl[i].e_if_rvalid));
      chk($sformatf("v%0d dm_done", i),   32'(bus.dm_done),   32'(tbl[i].e_dm_done));
      if (tbl[i].e_rd || tbl[i].e_wr)
        chk($sformatf("v%0d ram_address", i), 32'(bus.ram_address), 32'(tbl[i].e_addr));
      if (tbl[i].e_data_chk) begin
        if (tbl[i].e_wr)
          chk($sformatf("v%0d ram_data_in", i), bus.ram_data_in, tbl[i].e_data);
        else if (tbl[i].e_if_rvalid)
          chk($sformatf("v%0d if_rdata", i), bus.if_rdata, tbl[i].e_data);
        else
          chk($sformatf("v%0d dm_rdata", i), bus.dm_rdata, tbl[i].e_data);
      end
    end

    // Reset during the ISSUE cycle of a write: no completion, no write performed.
    @(posedge clk); #1 drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0030, 32'h1234_5678);
    @(negedge clk);
    chk("rstmid gnt", 32'(bus.dm_gnt), 32'h1);
    @(posedge clk); #1 drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk("rstmid issue wr", 32'(bus.ram_write), 32'h1);
    #1 rst = 1'b1;
    #1 chk_all_zero("rstmid");
    @(posedge clk); #1 rst = 1'b0;
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0030, 32'h0);
    @(negedge clk);
    chk("post-rst first gnt", 32'(bus.dm_gnt), 32'h1);
    chk("post-rst no done",   32'(bus.dm_done), 32'h0);
    @(posedge clk); #1 drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk("post-rst rd",   32'(bus.ram_read),    32'h1);
    chk("post-rst addr", 32'(bus.ram_address), 32'h0030);
    @(negedge clk);
    chk("post-rst done",  32'(bus.dm_done),  32'h1);
    chk("post-rst rdata", bus.dm_rdata,      32'h0);

    // Fetch pulse while busy is ignored and never reaches the RAM.
    @(negedge clk);
    acc0 = n_access;
    @(posedge clk); #1 drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 32'h0);
    @(negedge clk);
    chk("busy dm_gnt", 32'(bus.dm_gnt), 32'h1);
    @(posedge clk); #1 drive(1'b1, 16'h0050, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk("busy issue if_gnt", 32'(bus.if_gnt),      32'h0);
    chk("busy issue addr",   32'(bus.ram_address), 32'h0010);
    @(posedge clk); #1 drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk("busy resp if_gnt",  32'(bus.if_gnt), 32'h0);
    chk("busy resp done",    32'(bus.dm_done), 32'h1);
    chk("busy resp rdata",   bus.dm_rdata,     D_BEEF);
    repeat (3) @(negedge clk);
    chk("busy idle if_gnt",  32'(bus.if_gnt),   32'h0);
    chk("busy idle ram_read", 32'(bus.ram_read), 32'h0);
    chk("busy access count", 32'(n_access - acc0), 32'h1);
    chk("busy stray access", 32'(stray), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
